// File: rtl/psg_bus_master.sv
// psg_bus_master: drives the AY-3-8913/YM2149 BDIR/BC bus on behalf of an
// on-chip sequencer. Each request runs LATCH, GAP1, XFER, GAP2, paced by
// the I_CE bus-step enable. The LATCH phase and first gap are skipped when
// the PSG already holds the requested register address.
module psg_bus_master #(
   parameter int HOLD_TICKS  = 2,
   parameter int INACT_TICKS = 1,
   parameter int ADDR_CACHE  = 1
) (
   input  logic       CLK_14M,
   input  logic       I_RESET,
   input  logic       I_CE,
   input  logic       I_REQ_VALID,
   output logic       O_REQ_READY,
   input  logic       I_REQ_RW,
   input  logic [3:0] I_REQ_ADDR,
   input  logic [7:0] I_REQ_DATA,
   input  logic       I_FLUSH,
   output logic       O_RSP_VALID,
   output logic [7:0] O_RSP_DATA,
   output logic       O_BDIR,
   output logic       O_BC,
   output logic [7:0] O_DA_OUT,
   input  logic [7:0] I_DA_IN
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LATCH = 3'd1,
      GAP1  = 3'd2,
      XFER  = 3'd3,
      GAP2  = 3'd4
   } state_t;

   localparam logic [7:0] HOLD_LAST  = 8'(HOLD_TICKS - 1);
   localparam logic [7:0] INACT_LAST = 8'(INACT_TICKS - 1);

   state_t     state, state_n;
   logic [7:0] timer, timer_n;
   logic       bdir, bdir_n;
   logic       bc, bc_n;
   logic [7:0] da_out, da_out_n;
   logic       ready, ready_n;
   logic       rsp_valid, rsp_valid_n;
   logic [7:0] rsp_data, rsp_data_n;
   logic [3:0] cache_addr, cache_addr_n;
   logic       cache_valid, cache_valid_n;
   logic       req_rw, req_rw_n;
   logic [7:0] req_data, req_data_n;
   logic       cache_hit;
   logic       phase_done;

   // State and every bus-facing output are registered together
   always_ff @(posedge CLK_14M or posedge I_RESET) begin
      if (I_RESET) begin
         state       <= IDLE;
         timer       <= 8'd0;
         bdir        <= 1'b0;
         bc          <= 1'b0;
         da_out      <= 8'h00;
         ready       <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_data    <= 8'h00;
         cache_addr  <= 4'h0;
         cache_valid <= 1'b0;
         req_rw      <= 1'b0;
         req_data    <= 8'h00;
      end else begin
         state       <= state_n;
         timer       <= timer_n;
         bdir        <= bdir_n;
         bc          <= bc_n;
         da_out      <= da_out_n;
         ready       <= ready_n;
         rsp_valid   <= rsp_valid_n;
         rsp_data    <= rsp_data_n;
         cache_addr  <= cache_addr_n;
         cache_valid <= cache_valid_n;
         req_rw      <= req_rw_n;
         req_data    <= req_data_n;
      end
   end

   // Next state, phase timing, cache bookkeeping and next bus outputs
   always_comb begin
      state_n       = state;
      timer_n       = timer;
      bdir_n        = bdir;
      bc_n          = bc;
      da_out_n      = da_out;
      ready_n       = ready;
      rsp_valid_n   = 1'b0;
      rsp_data_n    = rsp_data;
      cache_addr_n  = cache_addr;
      cache_valid_n = cache_valid & ~I_FLUSH;
      req_rw_n      = req_rw;
      req_data_n    = req_data;

      // A flush in the accept cycle wins, so it forces a miss
      cache_hit  = (ADDR_CACHE != 0) && cache_valid && !I_FLUSH &&
                   (cache_addr == I_REQ_ADDR);
      phase_done = 1'b0;
      if (state == LATCH || state == XFER) begin
         phase_done = I_CE && (timer == HOLD_LAST);
      end else if (state == GAP1 || state == GAP2) begin
         phase_done = I_CE && (timer == INACT_LAST);
      end

      unique case (state)
         IDLE: begin
            if (I_REQ_VALID && ready) begin
               req_rw_n   = I_REQ_RW;
               req_data_n = I_REQ_DATA;
               ready_n    = 1'b0;
               timer_n    = 8'd0;
               if (cache_hit) begin
                  state_n  = XFER;
                  bdir_n   = ~I_REQ_RW;
                  bc_n     = I_REQ_RW;
                  da_out_n = I_REQ_RW ? 8'h00 : I_REQ_DATA;
               end else begin
                  state_n       = LATCH;
                  bdir_n        = 1'b1;
                  bc_n          = 1'b1;
                  da_out_n      = {4'h0, I_REQ_ADDR};
                  cache_addr_n  = I_REQ_ADDR;
                  cache_valid_n = 1'b1;
               end
            end
         end
         LATCH: begin
            if (phase_done) begin
               state_n = GAP1;
               timer_n = 8'd0;
               bdir_n  = 1'b0;
               bc_n    = 1'b0;
            end else if (I_CE) begin
               timer_n = timer + 8'd1;
            end
         end
         GAP1: begin
            if (phase_done) begin
               state_n  = XFER;
               timer_n  = 8'd0;
               bdir_n   = ~req_rw;
               bc_n     = req_rw;
               da_out_n = req_rw ? 8'h00 : req_data;
            end else if (I_CE) begin
               timer_n = timer + 8'd1;
            end
         end
         XFER: begin
            if (phase_done) begin
               state_n = GAP2;
               timer_n = 8'd0;
               bdir_n  = 1'b0;
               bc_n    = 1'b0;
               if (req_rw) begin
                  rsp_data_n  = I_DA_IN;
                  rsp_valid_n = 1'b1;
               end
            end else if (I_CE) begin
               timer_n = timer + 8'd1;
            end
         end
         GAP2: begin
            if (phase_done) begin
               state_n = IDLE;
               timer_n = 8'd0;
               ready_n = 1'b1;
            end else if (I_CE) begin
               timer_n = timer + 8'd1;
            end
         end
         default: begin
            state_n = IDLE;
            timer_n = 8'd0;
            bdir_n  = 1'b0;
            bc_n    = 1'b0;
            ready_n = 1'b1;
         end
      endcase
   end

   assign O_REQ_READY = ready;
   assign O_RSP_VALID = rsp_valid;
   assign O_RSP_DATA  = rsp_data;
   assign O_BDIR      = bdir;
   assign O_BC        = bc;
   assign O_DA_OUT    = da_out;

endmodule

// File: tb/tb_psg_bus_master.sv
// tb_psg_bus_master: directed bench for psg_bus_master with default
// parameters (HOLD_TICKS=2, INACT_TICKS=1, ADDR_CACHE=1) and I_CE every
// 14 clocks. A tiny PSG model answers reads from the latched address.
module tb_psg_bus_master;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ce = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_rw = 1'b0;
   logic [3:0] req_addr = 4'h0;
   logic [7:0] req_data = 8'h00;
   logic       flush = 1'b0;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       bdir;
   logic       bc;
   logic [7:0] da_out;
   logic [7:0] da_in;

   int compared = 0;
   int mismatched = 0;

   logic [3:0] psg_addr = 4'h0;
   logic [1:0] prev_code = 2'b00;
   int         rsp_pulses = 0;
   int         accepts = 0;
   int         bad_codes = 0;
   logic [3:0] latch_q[$];
   logic [7:0] write_q[$];

   psg_bus_master dut (
      .CLK_14M     (clk),
      .I_RESET     (rst),
      .I_CE        (ce),
      .I_REQ_VALID (req_valid),
      .O_REQ_READY (req_ready),
      .I_REQ_RW    (req_rw),
      .I_REQ_ADDR  (req_addr),
      .I_REQ_DATA  (req_data),
      .I_FLUSH     (flush),
      .O_RSP_VALID (rsp_valid),
      .O_RSP_DATA  (rsp_data),
      .O_BDIR      (bdir),
      .O_BC        (bc),
      .O_DA_OUT    (da_out),
      .I_DA_IN     (da_in)
   );

   // 100 MHz-ish bench clock; the absolute rate is irrelevant to the design
   always #5 clk = ~clk;

   // PSG model: remembers the latched register, returns 0xA5 for register 8
   always @(posedge clk) begin
      if ({bdir, bc} == 2'b11) psg_addr <= da_out[3:0];
   end
   assign da_in = (psg_addr == 4'd8) ? 8'hA5 : {4'h5, psg_addr};

   // Accepted requests are counted at the edge where the handshake completes
   always @(posedge clk) begin
      if (!rst && req_valid && req_ready) accepts <= accepts + 1;
   end

   // Bus monitor: logs phase entries, response pulses and illegal code sequences
   always @(negedge clk) begin
      if ({bdir, bc} == 2'b11 && prev_code != 2'b11) latch_q.push_back(da_out[3:0]);
      if ({bdir, bc} == 2'b10 && prev_code != 2'b10) write_q.push_back(da_out);
      if ((prev_code == 2'b10 && {bdir, bc} == 2'b11) ||
          (prev_code == 2'b11 && {bdir, bc} == 2'b10)) bad_codes <= bad_codes + 1;
      if ({bdir, bc} == 2'b11 && da_out[7:4] != 4'h0) bad_codes <= bad_codes + 1;
      if (rsp_valid) rsp_pulses <= rsp_pulses + 1;
      prev_code <= {bdir, bc};
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One bus step: 13 quiet clocks then one clock with I_CE high
   task automatic tick();
      ce = 1'b0;
      repeat (13) @(negedge clk);
      ce = 1'b1;
      @(negedge clk);
      ce = 1'b0;
   endtask

   // Present one request for a single clock; returns just after the accept edge
   task automatic applyStimulus(input logic rw, input logic [3:0] addr,
                                input logic [7:0] data, input logic with_flush,
                                input logic with_ce);
      req_valid = 1'b1;
      req_rw    = rw;
      req_addr  = addr;
      req_data  = data;
      flush     = with_flush;
      ce        = with_ce;
      @(negedge clk);
      req_valid = 1'b0;
      flush     = 1'b0;
      ce        = 1'b0;
   endtask

   task automatic runPhase(input string tag, input logic [1:0] code,
                           input logic [7:0] da, input int ticks);
      for (int i = 0; i < ticks; i++) begin
         checkOutput($sformatf("%s_bus%0d", tag, i), 16'({bdir, bc, da_out}),
                     16'({code, da}));
         checkOutput($sformatf("%s_ready%0d", tag, i), 16'(req_ready), 16'd0);
         tick();
      end
   endtask

   task automatic expectWrite(input logic [3:0] addr, input logic [7:0] data,
                              input logic miss);
      int pulses0;
      pulses0 = rsp_pulses;
      if (miss) begin
         runPhase("wr_latch", 2'b11, {4'h0, addr}, 2);
         runPhase("wr_gap1", 2'b00, {4'h0, addr}, 1);
      end
      runPhase("wr_xfer", 2'b10, data, 2);
      runPhase("wr_gap2", 2'b00, data, 1);
      checkOutput("wr_ready_back", 16'(req_ready), 16'd1);
      checkOutput("wr_idle_bus", 16'({bdir, bc}), 16'd0);
      checkOutput("wr_no_rsp", 16'(rsp_pulses - pulses0), 16'd0);
   endtask

   task automatic expectRead(input logic [3:0] addr, input logic [7:0] data,
                             input logic miss);
      int pulses0;
      pulses0 = rsp_pulses;
      if (miss) begin
         runPhase("rd_latch", 2'b11, {4'h0, addr}, 2);
         runPhase("rd_gap1", 2'b00, {4'h0, addr}, 1);
      end
      runPhase("rd_xfer", 2'b01, 8'h00, 2);
      checkOutput("rd_rsp_valid", 16'(rsp_valid), 16'd1);
      checkOutput("rd_rsp_data", 16'(rsp_data), 16'(data));
      runPhase("rd_gap2", 2'b00, 8'h00, 1);
      checkOutput("rd_ready_back", 16'(req_ready), 16'd1);
      checkOutput("rd_one_pulse", 16'(rsp_pulses - pulses0), 16'd1);
      checkOutput("rd_rsp_held", 16'(rsp_data), 16'(data));
   endtask

   // Directed sequence covering miss, hit, read, flush, reset and back-to-back
   initial begin
      int acc0;
      int lat0;
      int wr0;

      repeat (3) @(negedge clk);
      checkOutput("rst_ready", 16'(req_ready), 16'd1);
      checkOutput("rst_bus", 16'({bdir, bc, da_out}), 16'd0);
      checkOutput("rst_rsp", 16'({rsp_valid, rsp_data}), 16'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] write miss reg 7");
      applyStimulus(1'b0, 4'd7, 8'h38, 1'b0, 1'b0);
      expectWrite(4'd7, 8'h38, 1'b1);

      $display("[TB] write hit reg 7, I_CE on the accept edge");
      applyStimulus(1'b0, 4'd7, 8'h3F, 1'b0, 1'b1);
      expectWrite(4'd7, 8'h3F, 1'b0);

      $display("[TB] read miss reg 8");
      applyStimulus(1'b1, 4'd8, 8'h00, 1'b0, 1'b0);
      expectRead(4'd8, 8'hA5, 1'b1);

      $display("[TB] flush then write reg 8");
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      applyStimulus(1'b0, 4'd8, 8'h44, 1'b0, 1'b0);
      expectWrite(4'd8, 8'h44, 1'b1);
      applyStimulus(1'b0, 4'd8, 8'h55, 1'b1, 1'b0);
      expectWrite(4'd8, 8'h55, 1'b1);
      applyStimulus(1'b0, 4'd8, 8'h66, 1'b0, 1'b0);
      expectWrite(4'd8, 8'h66, 1'b0);
      checkOutput("rsp_held_after_writes", 16'(rsp_data), 16'h00A5);

      $display("[TB] reset during write transfer");
      applyStimulus(1'b0, 4'd5, 8'h11, 1'b0, 1'b0);
      runPhase("rs_latch", 2'b11, 8'h05, 2);
      runPhase("rs_gap1", 2'b00, 8'h05, 1);
      checkOutput("rs_xfer_bus", 16'({bdir, bc, da_out}), 16'({2'b10, 8'h11}));
      repeat (5) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      checkOutput("rs_async_bus", 16'({bdir, bc, da_out}), 16'd0);
      checkOutput("rs_async_ready", 16'(req_ready), 16'd1);
      checkOutput("rs_async_rsp", 16'({rsp_valid, rsp_data}), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      applyStimulus(1'b0, 4'd5, 8'h22, 1'b0, 1'b0);
      expectWrite(4'd5, 8'h22, 1'b1);

      $display("[TB] back-to-back writes to regs 0, 1, 0");
      acc0 = accepts;
      lat0 = latch_q.size();
      wr0  = write_q.size();
      req_valid = 1'b1;
      req_rw    = 1'b0;
      req_addr  = 4'd0;
      req_data  = 8'h10;
      @(negedge clk);
      req_addr = 4'd1;
      req_data = 8'h21;
      expectWrite(4'd0, 8'h10, 1'b1);
      @(negedge clk);
      req_addr = 4'd0;
      req_data = 8'h32;
      expectWrite(4'd1, 8'h21, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      expectWrite(4'd0, 8'h32, 1'b1);
      repeat (3) tick();
      checkOutput("b2b_accepts", 16'(accepts - acc0), 16'd3);
      checkOutput("b2b_latches", 16'(latch_q.size() - lat0), 16'd3);
      checkOutput("b2b_writes", 16'(write_q.size() - wr0), 16'd3);
      if (latch_q.size() >= lat0 + 3 && write_q.size() >= wr0 + 3) begin
         checkOutput("b2b_latch0", 16'(latch_q[lat0]), 16'd0);
         checkOutput("b2b_latch1", 16'(latch_q[lat0 + 1]), 16'd1);
         checkOutput("b2b_latch2", 16'(latch_q[lat0 + 2]), 16'd0);
         checkOutput("b2b_write0", 16'(write_q[wr0]), 16'h0010);
         checkOutput("b2b_write1", 16'(write_q[wr0 + 1]), 16'h0021);
         checkOutput("b2b_write2", 16'(write_q[wr0 + 2]), 16'h0032);
      end
      checkOutput("total_latches", 16'(latch_q.size()), 16'd9);
      checkOutput("code_sequence_errors", 16'(bad_codes), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
